// File: rtl/dla_filter_bias_scale_scratchpad_pkg.sv
// Shared types for the filter/bias/scale scratchpad writer.
// Holds the FSM state enum, the latched command bundle and a last-word helper.
package dla_filter_bias_scale_scratchpad_pkg;

    // Command counts are carried at this width internally; the
    // configurable CNT_WIDTH ports are zero-extended into it.
    localparam int CNT_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILTER = 2'd1,
        ST_BIAS   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] num_filter;
        logic [CNT_MAX_W-1:0] num_bias;
    } cmd_t;

    function automatic logic is_last(
        input logic [CNT_MAX_W-1:0] cnt,
        input logic [CNT_MAX_W-1:0] num
    );
        return cnt == (num - CNT_MAX_W'(1));
    endfunction

endpackage

// File: rtl/dla_filter_bias_scale_scratchpad_writer_out_reg.sv
// Single-entry valid/ready pipeline register (full throughput, no bubble).
// Ports: clk, aresetn, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module dla_fbs_writer_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    // Accept whenever the slot is empty or is being drained this cycle.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (in_ready) begin
                out_valid <= in_valid;
            end
            if (in_valid && in_ready) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/dla_filter_bias_scale_scratchpad_writer.sv
// Streams filter words then bias words from the DDR reader into the scratchpad.
// Ports: clk, i_aresetn, cmd (valid/ready/num_filter/num_bias), source stream
// (i_data_valid/o_data_ready/i_data), write sender (o_wr_valid/i_wr_ready/
// o_wr_is_filter/o_wr_addr/o_wr_data), o_done pulse.
// Optional macro DLA_FBS_WRITER_STALL_CNT_EN adds o_stall_cycles (32 bits).
module dla_filter_bias_scale_scratchpad_writer
    import dla_filter_bias_scale_scratchpad_pkg::*;
#(
    parameter int MAX_DATA_WIDTH = 512,
    parameter int ADDR_WIDTH     = 10,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      i_aresetn,
    input  logic                      i_cmd_valid,
    output logic                      o_cmd_ready,
    input  logic [CNT_WIDTH-1:0]      i_cmd_num_filter,
    input  logic [CNT_WIDTH-1:0]      i_cmd_num_bias,
    input  logic                      i_data_valid,
    output logic                      o_data_ready,
    input  logic [MAX_DATA_WIDTH-1:0] i_data,
    output logic                      o_wr_valid,
    input  logic                      i_wr_ready,
    output logic                      o_wr_is_filter,
    output logic [ADDR_WIDTH-1:0]     o_wr_addr,
    output logic [MAX_DATA_WIDTH-1:0] o_wr_data,
    output logic                      o_done
`ifdef DLA_FBS_WRITER_STALL_CNT_EN
    ,
    output logic [31:0]               o_stall_cycles
`endif
);

    localparam int PW = 1 + ADDR_WIDTH + MAX_DATA_WIDTH;

    state_e               state;
    state_e               state_nxt;
    cmd_t                 cmd_in;
    cmd_t                 cmd_q;
    logic [CNT_MAX_W-1:0] word_cnt;
    logic [CNT_MAX_W-1:0] cur_num;
    logic [ADDR_WIDTH-1:0] filt_addr;
    logic [ADDR_WIDTH-1:0] bias_addr;
    logic [ADDR_WIDTH-1:0] cur_addr;

    logic          cmd_fire;
    logic          xfer;
    logic          in_phase;
    logic          is_filter;
    logic          last_word;
    logic          drained;
    logic          reg_in_valid;
    logic          reg_in_ready;
    logic [PW-1:0] reg_in_data;
    logic [PW-1:0] reg_out_data;

    always_comb begin
        cmd_in            = '0;
        cmd_in.num_filter = CNT_MAX_W'(i_cmd_num_filter);
        cmd_in.num_bias   = CNT_MAX_W'(i_cmd_num_bias);
    end

    assign is_filter = (state == ST_FILTER);
    assign in_phase  = (state == ST_FILTER) || (state == ST_BIAS);
    assign cur_num   = is_filter ? cmd_q.num_filter : cmd_q.num_bias;
    assign cur_addr  = is_filter ? filt_addr : bias_addr;
    assign last_word = is_last(word_cnt, cur_num);
    assign cmd_fire  = i_cmd_valid && o_cmd_ready;
    assign xfer      = i_data_valid && o_data_ready;
    assign drained   = !o_wr_valid || i_wr_ready;

    // State register
    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (cmd_in.num_filter != '0) begin
                        state_nxt = ST_FILTER;
                    end else if (cmd_in.num_bias != '0) begin
                        state_nxt = ST_BIAS;
                    end else begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_FILTER: begin
                if (xfer && last_word) begin
                    state_nxt = (cmd_q.num_bias != '0) ? ST_BIAS : ST_DONE;
                end
            end
            ST_BIAS: begin
                if (xfer && last_word) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (drained) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs. Command ready is gated by reset so it reads 0 while held.
    always_comb begin
        o_cmd_ready  = i_aresetn && (state == ST_IDLE);
        o_data_ready = in_phase && reg_in_ready;
        o_done       = (state == ST_DONE) && drained;
    end

    // Counts, per-phase word counter and per-phase addresses
    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            cmd_q     <= '0;
            word_cnt  <= '0;
            filt_addr <= '0;
            bias_addr <= '0;
        end else if (cmd_fire) begin
            cmd_q     <= cmd_in;
            word_cnt  <= '0;
            filt_addr <= '0;
            bias_addr <= '0;
        end else if (xfer) begin
            word_cnt <= last_word ? '0 : word_cnt + CNT_MAX_W'(1);
            if (is_filter) begin
                filt_addr <= filt_addr + ADDR_WIDTH'(1);
            end else begin
                bias_addr <= bias_addr + ADDR_WIDTH'(1);
            end
        end
    end

    assign reg_in_valid = i_data_valid && in_phase;
    assign reg_in_data  = {is_filter, cur_addr, i_data};

    dla_fbs_writer_out_reg #(
        .W (PW)
    ) u_out_reg (
        .clk       (clk),
        .aresetn   (i_aresetn),
        .in_valid  (reg_in_valid),
        .in_ready  (reg_in_ready),
        .in_data   (reg_in_data),
        .out_valid (o_wr_valid),
        .out_ready (i_wr_ready),
        .out_data  (reg_out_data)
    );

    assign {o_wr_is_filter, o_wr_addr, o_wr_data} = reg_out_data;

`ifdef DLA_FBS_WRITER_STALL_CNT_EN
    // Backpressure cycles seen by the write sender, saturating.
    always_ff @(posedge clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            o_stall_cycles <= '0;
        end else if (cmd_fire) begin
            o_stall_cycles <= '0;
        end else if (o_wr_valid && !i_wr_ready && (o_stall_cycles != '1)) begin
            o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/dla_filter_bias_scale_scratchpad_writer.md
DLA_FILTER_BIAS_SCALE_SCRATCHPAD_WRITER -- requirements
Module: dla_filter_bias_scale_scratchpad_writer

Interface
REQ-001 SHALL have parameter MAX_DATA_WIDTH, default 512, meaning the payload width of one scratchpad write word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, meaning the scratchpad word-address width.
REQ-003 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the per-command word counts.
REQ-004 SHALL have port clk, input, 1, the single clock for all logic.
REQ-005 SHALL have port i_aresetn, input, 1, the asynchronous active-low reset.
REQ-006 SHALL have ports i_cmd_valid (in, 1), o_cmd_ready (out, 1), i_cmd_num_filter (in, CNT_WIDTH) and i_cmd_num_bias (in, CNT_WIDTH), forming a command handshake that gives the word counts per phase.
REQ-007 SHALL have ports i_data_valid (in, 1), o_data_ready (out, 1) and i_data (in, MAX_DATA_WIDTH), forming the source stream from the DDR reader.
REQ-008 SHALL have ports o_wr_valid (out, 1), i_wr_ready (in, 1), o_wr_is_filter (out, 1), o_wr_addr (out, ADDR_WIDTH) and o_wr_data (out, MAX_DATA_WIDTH), forming the scratchpad write-data sender.
REQ-009 SHALL have port o_done, out, 1, a one-cycle pulse when a command completes.

Function
REQ-010 SHALL implement FSM states IDLE, FILTER, BIAS and DONE.
REQ-011 o_cmd_ready SHALL be 1 only in IDLE; a command is accepted when i_cmd_valid and o_cmd_ready are both 1.
REQ-012 On command accept, the FSM SHALL move to FILTER if num_filter != 0, else to BIAS if num_bias != 0, else to DONE.
REQ-013 A source word SHALL transfer when i_data_valid and o_data_ready are both 1; o_data_ready SHALL be 0 in IDLE and DONE.
REQ-014 SHALL use a single output register: o_data_ready = in-phase and (!o_wr_valid or i_wr_ready), giving full throughput with no bubble.
REQ-015 An accepted word SHALL appear on o_wr_* on the next cycle (latency 1), held stable while o_wr_valid and !i_wr_ready.
REQ-016 o_wr_is_filter SHALL be 1 for FILTER-phase words and 0 for BIAS-phase words.
REQ-017 Filter and bias phases SHALL each use their own address counter, each starting at 0 per command and incrementing by 1 per accepted word, wrapping modulo 2^ADDR_WIDTH.
REQ-018 A phase SHALL end on acceptance of its final word (counter == count-1): FILTER then goes to BIAS, or to DONE if num_bias == 0; BIAS goes to DONE.
REQ-019 DONE SHALL wait until the output register is drained (o_wr_valid == 0, or i_wr_ready in that cycle), then pulse o_done for exactly one cycle and return to IDLE.
REQ-020 When both counts are 0, o_done SHALL pulse on the cycle after command accept and no write SHALL be emitted.
REQ-021 Counts SHALL be latched at accept; command inputs are don't-care outside IDLE.

Reset
REQ-022 Asserting i_aresetn low at any time SHALL immediately force the FSM to IDLE, clear both address counters and the count registers, and drive o_wr_valid=0, o_done=0, o_data_ready=0 and o_cmd_ready=0 while asserted.
REQ-023 o_wr_data, o_wr_addr and o_wr_is_filter SHALL reset to 0; an in-flight command is discarded with no o_done.
REQ-024 o_cmd_ready SHALL be 1 on the first clock edge after deassertion.

Configuration
REQ-025 With macro DLA_FBS_WRITER_STALL_CNT_EN defined, the block SHALL add output o_stall_cycles (32 bits), counting cycles where o_wr_valid and !i_wr_ready, saturating at all-ones, cleared on reset and on command accept.
REQ-026 Without the macro, the port and the counter SHALL be absent.

Structure
REQ-027 The state enum and the command struct (num_filter, num_bias) SHALL live in dla_filter_bias_scale_scratchpad_pkg.
REQ-028 The output register SHALL be a sub-module dla_fbs_writer_out_reg (valid/ready single-entry pipeline register).

Verification
REQ-029 Command (3,2) with data always valid and ready always high -> 5 writes on consecutive cycles: filter addresses 0,1,2 (is_filter=1), then bias addresses 0,1 (is_filter=0); o_done one cycle after the last write.
REQ-030 Command (0,0) -> no o_wr_valid; o_done pulses exactly 1 cycle after accept; o_cmd_ready returns to 1.
REQ-031 Command (4,0) with i_wr_ready low for 3 cycles on the 2nd word -> o_wr_data/o_wr_addr held stable; data order and addresses 0..3 intact; no drops or duplicates.
REQ-032 ADDR_WIDTH=2, command (6,0) -> filter addresses 0,1,2,3,0,1.
REQ-033 Reset asserted mid-FILTER after 2 of 5 words -> all outputs 0 immediately; after release, a new command (1,1) completes normally with addresses starting at 0.
REQ-034 With DLA_FBS_WRITER_STALL_CNT_EN defined, 7 backpressure cycles during a command -> o_stall_cycles == 7; a new accept clears it to 0.
